key_exp_ctrl: RTL

//  Sequencer for the byte-serial AES-128 key-expansion datapath (key array + rcon mux + S-box feedback).

---
 rtl/key_exp_ctrl.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/key_exp_ctrl.sv
// Sequencer for the byte-serial AES-128 key-expansion datapath: user-key load, round shifts, rcon and round-key writes.
// Optional abort input is enabled by defining KEY_EXP_ABORT_EN.
module key_exp_ctrl #(
  parameter int         NUM_ROUNDS  = 10,
  parameter int         WORD_ADDR_W = 6,
  parameter logic [7:0] RCON_INIT   = 8'h01
) (
  input  logic                   gated_clk_ff,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   user_key_valid,
`ifdef KEY_EXP_ABORT_EN
  input  logic                   abort,
`endif
  output logic                   user_key_ready,
  output logic                   en_key_exp,
  output logic                   key_selector,
  output logic                   rcon_sel,
  output logic                   key_gen_sel,
  output logic [7:0]             rcon_output,
  output logic                   key_mem_we,
  output logic [WORD_ADDR_W-1:0] key_mem_addr,
  output logic                   busy,
  output logic                   done
);

  // Round counter must reach NUM_ROUNDS+1 after the final increment.
  localparam int                ROUND_W    = $clog2(NUM_ROUNDS + 2);
  localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(NUM_ROUNDS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_EXPAND,
    S_DONE
  } state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic [3:0]           r_byte_cnt;
  logic [ROUND_W-1:0]   r_round_cnt;
  logic [7:0]           r_rcon;
  logic                 r_we;
  logic [WORD_ADDR_W-1:0] r_addr;

  logic                 w_abort;
  logic                 w_last_byte;
  logic                 w_last_round;
  logic                 w_word_done;
  logic [ROUND_W+1:0]   w_word_addr;

  function automatic logic [7:0] xtime(input logic [7:0] v);
    return {v[6:0], 1'b0} ^ (v[7] ? 8'h1B : 8'h00);
  endfunction

`ifdef KEY_EXP_ABORT_EN
  assign w_abort = abort & ((r_state == S_LOAD) | (r_state == S_EXPAND));
`else
  assign w_abort = 1'b0;
`endif

  assign w_last_byte  = (r_byte_cnt == 4'd15);
  assign w_last_round = (r_round_cnt == LAST_ROUND);
  assign w_word_done  = en_key_exp & (r_byte_cnt[1:0] == 2'b11);
  assign w_word_addr  = {r_round_cnt, r_byte_cnt[3:2]};

  assign rcon_output  = r_rcon;
  assign key_mem_we   = r_we;
  assign key_mem_addr = r_addr;

  always_ff @(posedge gated_clk_ff or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state   = r_state;
    user_key_ready = 1'b0;
    en_key_exp     = 1'b0;
    key_selector   = 1'b0;
    rcon_sel       = 1'b0;
    key_gen_sel    = 1'b0;
    busy           = 1'b0;
    done           = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next_state = S_LOAD;
        end
      end
      S_LOAD: begin
        busy           = 1'b1;
        user_key_ready = 1'b1;
        en_key_exp     = user_key_valid & ~w_abort;
        if (en_key_exp && w_last_byte) begin
          w_next_state = S_EXPAND;
        end
      end
      S_EXPAND: begin
        busy         = 1'b1;
        key_selector = 1'b1;
        en_key_exp   = ~w_abort;
        key_gen_sel  = (r_byte_cnt < 4'd4);
        rcon_sel     = (r_byte_cnt == 4'd0);
        if (w_last_byte && w_last_round) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        done         = 1'b1;
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
    // Abort wins over any transition decided above.
    if (w_abort) begin
      w_next_state = S_IDLE;
    end
  end

  always_ff @(posedge gated_clk_ff or posedge rst) begin
    if (rst) begin
      r_byte_cnt  <= 4'd0;
      r_round_cnt <= '0;
      r_rcon      <= RCON_INIT;
    end else if (w_abort) begin
      r_byte_cnt  <= 4'd0;
      r_round_cnt <= '0;
      r_rcon      <= RCON_INIT;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_byte_cnt  <= 4'd0;
            r_round_cnt <= '0;
            r_rcon      <= RCON_INIT;
          end
        end
        S_LOAD: begin
          if (en_key_exp) begin
            r_byte_cnt <= r_byte_cnt + 4'd1;
            if (w_last_byte) begin
              r_round_cnt <= ROUND_W'(1);
            end
          end
        end
        S_EXPAND: begin
          r_byte_cnt <= r_byte_cnt + 4'd1;
          if (w_last_byte) begin
            r_rcon      <= xtime(r_rcon);
            r_round_cnt <= r_round_cnt + ROUND_W'(1);
          end
        end
        default: begin
          r_byte_cnt <= r_byte_cnt;
        end
      endcase
    end
  end

  // A word write trails its completing shift by one cycle; the last one lands in DONE.
  always_ff @(posedge gated_clk_ff or posedge rst) begin
    if (rst) begin
      r_we   <= 1'b0;
      r_addr <= '0;
    end else begin
      r_we <= w_word_done;
      if (w_word_done) begin
        r_addr <= WORD_ADDR_W'(w_word_addr);
      end
    end
  end

endmodule
